// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, Start/Busy/Done handshake.
// Latency: Done is high in the cycle after the edge E_WIDTH (E0 = Start accepted); divide-by-zero finishes after E0.
// Backpressure: none queued; Start is sampled only in IDLE, and requests arriving while Busy are dropped.
//
// Ports:
//   Clock, Resetn         rising-edge clock, asynchronous active-low reset
//   Start                 request, sampled only while idle
//   Dividend, Divisor     WIDTH-bit unsigned operands, captured on accepted Start
//   Quotient, Remainder   registered results, held until the next Done
//   Busy                  high while a division is running or completing
//   Done                  one-cycle pulse in the cycle the results update
//   DivByZero             registered flag, updated together with Done
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH:0]   r_q, r_nxt;        // partial remainder, one extra bit for the sign of the trial
    logic [WIDTH-1:0] q_q, q_nxt;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] d_q, d_nxt;        // captured divisor
    logic [CW-1:0]    cnt_q, cnt_nxt;    // iterations still to run

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_trial;

    logic             load_res;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] rem_nxt;
    logic             dbz_nxt;

    // {R,Q} shifted left by one, then the trial subtraction. A set MSB of the
    // trial means the divisor did not fit and the shifted remainder is kept.
    assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign r_trial = r_shift - {1'b0, d_q};

    always_comb begin
        state_nxt = state;
        r_nxt     = r_q;
        q_nxt     = q_q;
        d_nxt     = d_q;
        cnt_nxt   = cnt_q;
        load_res  = 1'b0;
        quo_nxt   = '0;
        rem_nxt   = '0;
        dbz_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (Start) begin
                    d_nxt = Divisor;
                    if (Divisor == '0) begin
                        // No iterations: report all-ones quotient and the dividend as remainder.
                        state_nxt = DONE;
                        load_res  = 1'b1;
                        quo_nxt   = '1;
                        rem_nxt   = Dividend;
                        dbz_nxt   = 1'b1;
                    end else begin
                        state_nxt = RUN;
                        r_nxt     = '0;
                        q_nxt     = Dividend;
                        cnt_nxt   = CW'(WIDTH);
                    end
                end
            end

            RUN: begin
                cnt_nxt = cnt_q - CW'(1);
                q_nxt   = {q_q[WIDTH-2:0], ~r_trial[WIDTH]};
                r_nxt   = r_trial[WIDTH] ? r_shift : r_trial;
                if (cnt_q == CW'(1)) begin
                    // Last iteration: results are loaded on the same edge that enters DONE.
                    state_nxt = DONE;
                    load_res  = 1'b1;
                    quo_nxt   = q_nxt;
                    rem_nxt   = r_nxt[WIDTH-1:0];
                    dbz_nxt   = 1'b0;
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= IDLE;
            r_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            cnt_q     <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
        end else begin
            state <= state_nxt;
            r_q   <= r_nxt;
            q_q   <= q_nxt;
            d_q   <= d_nxt;
            cnt_q <= cnt_nxt;
            if (load_res) begin
                Quotient  <= quo_nxt;
                Remainder <= rem_nxt;
                DivByZero <= dbz_nxt;
            end
        end
    end

    // DONE lasts exactly one cycle, so the state decode is the Done pulse.
    assign Busy = (state != IDLE);
    assign Done = (state == DONE);

endmodule
